tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_pkg.sv | 19 +
 rtl/rr_select.sv | 33 +++
 rtl/tristate_bus_arbiter.sv | 114 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tristate_bus_pkg : shared FSM encoding and default sizing for the    |
// |                    tri-state bus arbiter.           Revision: 1.0    |
// +----------------------------------------------------------------------+
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int c_WIDTH     = 8;
    localparam int c_CHANNELS  = 4;
    localparam int c_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_select : combinational round-robin pick, searching upward from    |
// |             ptr+1 and wrapping to channel 0.        Revision: 1.0    |
// +----------------------------------------------------------------------+
module rr_select #(
    parameter int CHANNELS = 4,
    parameter int PTR_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [CHANNELS-1:0] pick,
    output logic                any
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        pick  = '0;
        any   = 1'b0;
        w_idx = '0;
        // offset CHANNELS lands back on ptr itself, so it has the lowest priority
        for (int k = 1; k <= CHANNELS; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % CHANNELS);
            if (!any && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tristate_bus_arbiter : round-robin owner of a shared tri-state bus   |
// |                        with bounded bursts and a dead turn cycle.    |
// |                                                     Revision: 1.0    |
// +----------------------------------------------------------------------+
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH,
    parameter int CHANNELS  = c_CHANNELS,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output wire  [WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]       grant,
    output logic                      bus_valid,
    output logic                      busy
);

    localparam int          c_PTR_W     = $clog2(CHANNELS);
    localparam logic [7:0]  c_BEAT_LAST = 8'(MAX_BURST - 1);

    state_t                r_state;
    logic [CHANNELS-1:0]   r_grant;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_PTR_W-1:0]    r_owner;
    logic [7:0]            r_beat_cnt;

    logic [CHANNELS-1:0]   w_pick;
    logic                  w_any;
    logic [c_PTR_W-1:0]    w_pick_idx;
    logic [WIDTH-1:0]      w_owner_data;
    logic                  w_owner_req;
    logic                  w_drive;

    rr_select #(
        .CHANNELS (CHANNELS),
        .PTR_W    (c_PTR_W)
    ) u_rr_select (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_pick[i]) w_pick_idx = c_PTR_W'(i);
        end
    end

    always_comb begin
        w_owner_data = '0;
        w_owner_req  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_owner == c_PTR_W'(i)) begin
                w_owner_data = in[i*WIDTH +: WIDTH];
                w_owner_req  = req[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= c_PTR_W'(CHANNELS - 1);
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_owner    <= w_pick_idx;
                        r_ptr      <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!w_owner_req || r_beat_cnt == c_BEAT_LAST) begin
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                        r_state    <= TURN;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // state is reset asynchronously, so the bus releases the moment rst rises
    assign w_drive   = (r_state == DRIVE);
    assign out       = w_drive ? w_owner_data : {WIDTH{1'bz}};
    assign bus_valid = w_drive && w_owner_req;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tristate_bus_arbiter : directed bench for the tri-state arbiter.  |
// |                                                     Revision: 1.0    |
// +----------------------------------------------------------------------+
module tb_tristate_bus_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    wire  [W-1:0]     bus;
    logic [N-1:0]     grant;
    logic             bus_valid, busy;

    logic [1:0]       req2;
    logic [2*W-1:0]   din2;
    wire  [W-1:0]     bus2;
    logic [1:0]       grant2;
    logic             bv2, busy2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.WIDTH(W), .CHANNELS(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .in(din),
        .out(bus), .grant(grant), .bus_valid(bus_valid), .busy(busy)
    );

    tristate_bus_arbiter #(.WIDTH(W), .CHANNELS(2), .MAX_BURST(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .in(din2),
        .out(bus2), .grant(grant2), .bus_valid(bv2), .busy(busy2)
    );

    // a two-state simulator resolves an undriven net to zero; all test data is nonzero
    function automatic bit released(input logic [W-1:0] v);
        return (v === {W{1'bz}}) || (v === {W{1'b0}});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        tests++;
        if (grant == '0 && !released(bus)) begin
            fails++;
            $display("FAIL bus_z_no_grant: bus=%h grant=%b, required Z", bus, grant);
        end
        tests++;
        if ($countones(grant) > 1) begin
            fails++;
            $display("FAIL grant_onehot: grant=%b, required at most one bit", grant);
        end
        tests++;
        if (grant2 == '0 && !released(bus2)) begin
            fails++;
            $display("FAIL bus2_z_no_grant: bus=%h grant=%b, required Z", bus2, grant2);
        end
    end

    task automatic test_reset();
        tests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || bus_valid !== 1'b0 || !released(bus)) begin
            fails++;
            $display("FAIL reset_state: grant=%b busy=%b valid=%b bus=%h, required 0000/0/0/Z",
                     grant, busy, bus_valid, bus);
        end
    endtask

    task automatic test_idle();
        req = '0;
        repeat (3) begin
            tick();
            tests++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_req: grant=%b busy=%b, required 0000/0", grant, busy);
            end
        end
    endtask

    task automatic test_burst();
        req = 4'b0101;
        tick();
        tests++;
        if (grant !== 4'b0001 || bus !== 8'h11 || bus_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL burst_first_grant: grant=%b bus=%h valid=%b, required 0001/11/1",
                     grant, bus, bus_valid);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            tests++;
            if (grant !== 4'b0001 || bus !== 8'h11) begin
                fails++;
                $display("FAIL burst_beat%0d: grant=%b bus=%h, required 0001/11", k, grant, bus);
            end
        end
        tick();
        tests++;
        if (grant !== 4'b0000 || !released(bus) || busy !== 1'b1 || bus_valid !== 1'b0) begin
            fails++;
            $display("FAIL burst_turn: grant=%b bus=%h busy=%b, required 0000/Z/1", grant, bus, busy);
        end
        tick();
        tests++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_idle: grant=%b busy=%b, required 0000/0", grant, busy);
        end
        tick();
        tests++;
        if (grant !== 4'b0100 || bus !== 8'hA5) begin
            fails++;
            $display("FAIL burst_next_owner: grant=%b bus=%h, required 0100/A5", grant, bus);
        end
        req = '0;
        tick();
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL burst_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_pulse();
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (grant !== 4'b0100 || bus !== 8'hA5 || bus_valid !== 1'b1) begin
                fails++;
                $display("FAIL pulse_beat%0d: grant=%b bus=%h valid=%b, required 0100/A5/1",
                         k, grant, bus, bus_valid);
            end
        end
        req = '0;
        #1;
        tests++;
        if (bus !== 8'hA5 || bus_valid !== 1'b0) begin
            fails++;
            $display("FAIL pulse_valid_live: bus=%h valid=%b, required A5/0", bus, bus_valid);
        end
        tick();
        tests++;
        if (!released(bus) || grant !== 4'b0000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pulse_turn: bus=%h grant=%b busy=%b, required Z/0000/1", bus, grant, busy);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || !released(bus)) begin
            fails++;
            $display("FAIL pulse_idle: busy=%b bus=%h, required 0/Z", busy, bus);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        int           ch;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            ch = i % N;
            tick();
            tests++;
            if (grant !== exp_g[i] || bus !== din[ch*W +: W]) begin
                fails++;
                $display("FAIL rr_grant%0d: grant=%b bus=%h, required %b/%h",
                         i, grant, bus, exp_g[i], din[ch*W +: W]);
            end
            repeat (3) tick();
            tests++;
            if (grant !== exp_g[i]) begin
                fails++;
                $display("FAIL rr_hold%0d: grant=%b, required %b", i, grant, exp_g[i]);
            end
            tick();
            tests++;
            if (grant !== 4'b0000 || !released(bus)) begin
                fails++;
                $display("FAIL rr_turn%0d: grant=%b bus=%h, required 0000/Z", i, grant, bus);
            end
            tick();
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_drive();
        req = 4'b0001;
        tick();
        tick();
        tests++;
        if (grant !== 4'b0001 || bus !== 8'h11) begin
            fails++;
            $display("FAIL mid_pre_reset: grant=%b bus=%h, required 0001/11", grant, bus);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (grant !== 4'b0000 || !released(bus) || busy !== 1'b0 || bus_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_async_reset: grant=%b bus=%h busy=%b valid=%b, required 0000/Z/0/0",
                     grant, bus, busy, bus_valid);
        end
        @(negedge clk);
        req = 4'b0011;
        rst = 1'b0;
        tick();
        tests++;
        if (grant !== 4'b0001 || bus !== 8'h11) begin
            fails++;
            $display("FAIL mid_ch0_first: grant=%b bus=%h, required 0001/11", grant, bus);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_min_burst();
        logic [1:0]   exp_g;
        logic [W-1:0] exp_d;
        req2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 8'h3C : 8'h5A;
            tick();
            tests++;
            if (grant2 !== exp_g || bus2 !== exp_d || bv2 !== 1'b1) begin
                fails++;
                $display("FAIL mb1_drive%0d: grant=%b bus=%h valid=%b, required %b/%h/1",
                         i, grant2, bus2, bv2, exp_g, exp_d);
            end
            tick();
            tests++;
            if (grant2 !== 2'b00 || busy2 !== 1'b1 || !released(bus2)) begin
                fails++;
                $display("FAIL mb1_turn%0d: grant=%b busy=%b bus=%h, required 00/1/Z",
                         i, grant2, busy2, bus2);
            end
            tick();
            tests++;
            if (grant2 !== 2'b00 || busy2 !== 1'b0) begin
                fails++;
                $display("FAIL mb1_idle%0d: grant=%b busy=%b, required 00/0", i, grant2, busy2);
            end
        end
        req2 = '0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        req2 = '0;
        din  = {8'h44, 8'hA5, 8'h22, 8'h11};
        din2 = {8'h5A, 8'h3C};
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_idle();
        test_burst();
        test_pulse();
        test_round_robin();
        test_reset_mid_drive();
        test_min_burst();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
